// File: rtl/iterative_muldiv.sv
// rtl/iterative_muldiv.sv - radix-2 multi-cycle signed/unsigned multiply and restoring divide
module iterative_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flow,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             busy,
  output logic             stall_X
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic               op_r, sa, sb;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]      cnt;

  logic               sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, addend, rem_diff;
  logic [WIDTH:0]     mul_sum, rem_shift;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign sign_a   = is_signed & a[WIDTH-1];
  assign sign_b   = is_signed & b[WIDTH-1];
  assign mag_a    = sign_a ? -a : a;
  assign mag_b    = sign_b ? -b : b;
  assign div_zero = op && (b == '0);

  assign busy    = (state != IDLE);
  // Gated by reset so a held start cannot freeze the pipeline while in reset.
  assign stall_X = rst_n && start && !(state == DONE && flow);

  // opnd holds the multiplicand (multiply) or divisor magnitude (divide).
  always_comb begin
    addend    = acc[0] ? opnd : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_ge    = (rem_shift >= {1'b0, opnd});
    rem_diff  = rem_shift[WIDTH-1:0] - opnd;
    if (op_r)
      acc_next = {(rem_ge ? rem_diff : rem_shift[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};
    else
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    prod_fix = (sa ^ sb) ? -acc_next : acc_next;
    quot_fix = (sa ^ sb) ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem_fix  = sa ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = div_zero ? DONE : CALC;
      CALC: begin
        if (!start)               state_next = IDLE;
        else if (cnt == CW'(1))   state_next = DONE;
      end
      DONE: if (!start || flow) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      cnt         <= '0;
      result      <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_r        <= op;
          sa          <= sign_a;
          sb          <= sign_b;
          cnt         <= CW'(WIDTH);
          opnd        <= op ? mag_b : mag_a;
          acc         <= {{WIDTH{1'b0}}, (op ? mag_a : mag_b)};
          div_by_zero <= div_zero;
          if (div_zero) begin
            result    <= '1;
            result_hi <= a;
          end
        end
        CALC: if (start) begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (op_r) begin
              result    <= quot_fix;
              result_hi <= rem_fix;
            end else begin
              result    <= prod_fix[WIDTH-1:0];
              result_hi <= prod_fix[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_muldiv.sv
// tb/tb_iterative_muldiv.sv - scoreboard bench for iterative_muldiv with directed vectors
module tb_iterative_muldiv;
  logic        clk = 1'b0;
  logic        rst_n, start, op, is_signed, flow;
  logic [15:0] a, b;
  logic [15:0] result, result_hi;
  logic        div_by_zero, busy, stall_X;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] r;
    logic [15:0] h;
    logic        d;
  } exp_t;
  exp_t exp_q[$];

  iterative_muldiv #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .flow(flow), .result(result), .result_hi(result_hi),
    .div_by_zero(div_by_zero), .busy(busy), .stall_X(stall_X)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a release cycle (DONE with flow) is where the stage latches the result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && start && busy && !stall_X) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {16'h0, result}, {16'h0, e.r});
          chk("result_hi", {16'h0, result_hi}, {16'h0, e.h});
          chk("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.d});
        end
      end
    end
  end

  task automatic run_op(input logic o, input logic s, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic [15:0] eh, input logic ed,
                        input int exp_stall, input int hold);
    int  n = 0;
    int  k = 0;
    bit  done = 0;
    exp_q.push_back('{r: er, h: eh, d: ed});
    op = o; is_signed = s; a = x; b = y; start = 1'b1;
    while (!done && k < 100) begin
      flow = (hold == 0) || (k >= exp_stall + hold);
      @(negedge clk);
      if (stall_X) n++;
      else done = 1;
      if (stall_X && hold > 0 && k >= exp_stall) begin
        chk("hold_result", {16'h0, result}, {16'h0, er});
        chk("hold_result_hi", {16'h0, result_hi}, {16'h0, eh});
      end
      @(posedge clk); #1;
      k++;
    end
    if (!done) chk("release_timeout", 32'd1, 32'd0);
    chk("stall_cycles", n, exp_stall + hold);
    start = 1'b0; flow = 1'b1;
    @(negedge clk);
    chk("idle_after", {31'h0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; is_signed = 1'b0; flow = 1'b1;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_result", {16'h0, result}, 32'h0);
    chk("rst_result_hi", {16'h0, result_hi}, 32'h0);
    chk("rst_dbz", {31'h0, div_by_zero}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_stall", {31'h0, stall_X}, 32'h0);
    @(posedge clk); #1;

    run_op(0, 0, 16'd300,  16'd200,  16'hEA60, 16'h0000, 0, 17, 0);
    run_op(0, 1, 16'hFFFD, 16'd5,    16'hFFF1, 16'hFFFF, 0, 17, 0);
    run_op(0, 1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 0, 17, 0);
    run_op(1, 1, 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 0, 17, 0);
    run_op(1, 0, 16'hFFF9, 16'd2,    16'h7FFC, 16'h0001, 0, 17, 0);
    run_op(1, 1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 17, 0);
    run_op(1, 1, 16'd7,    16'hFFFE, 16'hFFFD, 16'h0001, 0, 17, 0);
    run_op(1, 0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 1, 0);
    run_op(1, 0, 16'd10,   16'd3,    16'h0003, 16'h0001, 0, 17, 0);
    run_op(0, 0, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 0, 17, 4);

    // Flush: drop start during the fifth CALC cycle.
    op = 1'b0; is_signed = 1'b0; a = 16'd7; b = 16'd9; start = 1'b1; flow = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("flush_busy_before", {31'h0, busy}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk("flush_stall", {31'h0, stall_X}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_idle", {31'h0, busy}, 32'd0);
    chk("flush_result_held", {16'h0, result}, 32'hFFFF);
    chk("flush_result_hi_held", {16'h0, result_hi}, 32'h0000);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of CALC.
    op = 1'b1; is_signed = 1'b0; a = 16'h1111; b = 16'd2; start = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_result", {16'h0, result}, 32'h0);
    chk("arst_result_hi", {16'h0, result_hi}, 32'h0);
    chk("arst_dbz", {31'h0, div_by_zero}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_stall", {31'h0, stall_X}, 32'h0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 16'd2, 16'd3, 16'h0006, 16'h0000, 0, 17, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iterative_muldiv.md
# iterative_muldiv

Parametrised multi-cycle multiply/divide unit for the execute stage, for the MULT and DIV ALU operations. It replaces repeated-add and repeated-subtract iteration with a fixed-latency radix-2 engine: shift-add multiply and restoring divide, one bit per cycle. It handles signed and unsigned operands and returns the full double-width product or quotient plus remainder. It holds the pipeline through `stall_X` until the result is ready and the hazard unit asserts `flow`.

## Interface
Parameters:
- WIDTH, 16: operand and result width in bits; any value ≥ 4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  execute stage holds a MULT/DIV op; held high, with operands stable, while `stall_X` is high.
- op  in  1  0 = multiply, 1 = divide; sampled in IDLE.
- is_signed  in  1  1 = two's-complement operands; sampled in IDLE.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- flow  in  1  hazard unit: this block is the only stall source, so the pipeline may advance.
- result  out  WIDTH  low product half / quotient.
- result_hi  out  WIDTH  high product half / remainder.
- div_by_zero  out  1  last divide had b == 0.
- busy  out  1  state != IDLE.
- stall_X  out  1  freeze the pipeline.

## Operation
States:
- IDLE
  - If start: latch op, is_signed, sign of a (sa) and sign of b (sb) (zero when unsigned), |a| and |b| as WIDTH-bit unsigned magnitudes. Note |−2^(WIDTH−1)| = 2^(WIDTH−1).
  - Load counter = WIDTH, clear the accumulator, then go to CALC.
  - Exception: divide with b == 0 goes to DONE directly.
- CALC
  - Multiply: 2·WIDTH accumulator. Each cycle, if the multiplier LSB is 1, add the multiplicand into the high half, then shift right by 1.
  - Divide: restoring algorithm. Shift {rem,quot} left by 1; if rem ≥ |b|, set rem −= |b| and quot LSB = 1.
  - Decrement counter each cycle; the last step (counter == 1) goes to DONE.
- DONE
  - Result registers are loaded on the edge entering DONE.
  - If flow, return to IDLE on the next edge.
- Abort: start low in CALC or DONE returns to IDLE next edge (pipeline flush). Result registers keep their prior values.

Sign correction, applied when loading the results:
- Multiply: negate the 2·WIDTH product if sa ^ sb. result = low half, result_hi = high half.
- Divide: negate the quotient if sa ^ sb; the remainder takes the sign of the dividend (truncating division).
- Signed −2^(WIDTH−1) / −1: quotient wraps to 0x8000 (WIDTH = 16), remainder 0, div_by_zero = 0.

Divide by zero:
- result = all ones.
- result_hi = a unchanged.
- div_by_zero = 1.

Other rules:
- div_by_zero is cleared on every accepted op other than divide-by-zero.
- All outputs hold between ops.
- op, is_signed and operand changes are ignored outside IDLE.

## Timing
- Reset (asynchronous, immediate): state IDLE, result = 0, result_hi = 0, div_by_zero = 0, busy = 0, internal registers 0.
- stall_X = start && !(state == DONE && flow). This is combinational and low whenever start is low.
- Normal op: start is sampled in IDLE at cycle 0. CALC runs cycles 1..WIDTH, DONE is cycle WIDTH+1. With flow = 1, stall_X is high for exactly WIDTH+1 cycles and low in cycle WIDTH+1, which is when the stage latches result.
- Divide by zero: stall_X is high only in cycle 0; DONE is cycle 1.
- flow low in DONE: stay in DONE with stall_X high and results valid and stable. Release occurs in the first DONE cycle with flow = 1.
- Back-to-back ops: after DONE→IDLE, a new start is accepted in the next cycle. There is no dead cycle beyond IDLE.
- Arithmetic is WIDTH / 2·WIDTH unsigned internally with no carry loss. The multiply adder is WIDTH+1 bits and the divide compare is WIDTH+1 bits.

## Test plan
- Unsigned multiply, WIDTH = 16:
  - 300 × 200 gives result 0xEA60, result_hi 0x0000.
  - stall_X high for 17 cycles, then low with flow = 1.
- Signed multiply, (−3) × 5: result 0xFFF1, result_hi 0xFFFF. Then 0x8000 × 0x8000 signed gives result 0x0000, result_hi 0x4000.
- Signed divide:
  - (−7) / 2 gives result 0xFFFD, result_hi 0xFFFF.
  - Unsigned 0xFFF9 / 2 gives 0x7FFC, remainder 1.
  - Signed 0x8000 / 0xFFFF gives 0x8000, remainder 0.
- Divide by zero, 0x1234 / 0: result 0xFFFF, result_hi 0x1234, div_by_zero 1, stall_X high for 1 cycle. A following 10 / 3 gives 3, remainder 1, with div_by_zero cleared.
- Hold flow = 0 for 4 cycles in DONE:
  - stall_X stays high and results stay stable.
  - On flow = 1, stall_X drops that cycle and state is IDLE next cycle.
- Flush and reset:
  - Drop start at CALC cycle 5: unit is in IDLE next cycle, stall_X low, old results held.
  - Assert rst_n = 0 mid-CALC: all outputs 0 and state IDLE without waiting for a clock edge.
